// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and defaults for the PLL reset sequencer: state encoding,
// default timing constants and the counter width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN,
    LOST,
    PLL_RST
  } state_e;

  localparam int unsigned LOCK_CYCLES_DEF    = 1024;
  localparam int unsigned HOLD_CYCLES_DEF    = 16;
  localparam int unsigned RELOCK_TIMEOUT_DEF = 65536;
  localparam int unsigned PLL_RST_CYCLES_DEF = 8;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c,
                                            input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL, the reset sequencer and downstream logic.
// PLL_RESET_SEQUENCER_LOSS_COUNT_EN adds the loss_count status output.
interface pll_reset_sequencer_if;

  logic       pll_locked;
  logic       pll_rst;
  logic       core_reset;
  logic       ce_half;
  logic       ready;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
  logic [7:0] loss_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output core_reset,
    output ce_half,
    output ready,
    output loss_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  core_reset,
    input  ce_half,
    input  ready,
    input  loss_count
  );
`else
  modport master (
    input  pll_locked,
    output pll_rst,
    output core_reset,
    output ce_half,
    output ready
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  core_reset,
    input  ce_half,
    input  ready
  );
`endif

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop single-bit synchroniser with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock debounce, core reset sequencing, half-rate clock enable and relock
// timeout. Optional macro PLL_RESET_SEQUENCER_LOSS_COUNT_EN adds loss_count.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES    = LOCK_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int unsigned RELOCK_TIMEOUT = RELOCK_TIMEOUT_DEF,
  parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);

  localparam int unsigned CW = cnt_width(LOCK_CYCLES, HOLD_CYCLES,
                                         RELOCK_TIMEOUT, PLL_RST_CYCLES);

  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RELOCK_LAST = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PLL_RST_CYCLES - 1);

  logic          lock_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          pll_rst_q, pll_rst_d;
  logic          core_reset_q, core_reset_d;
  logic          ce_half_q, ce_half_d;
  logic          ready_q, ready_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (lock_s)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        // The detecting cycle is already the first locked cycle of the window.
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = CW'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= LOCK_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = LOST;
          cnt_d   = '0;
        end else if (cnt_q >= HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = LOST;
      end
      LOST: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= RELOCK_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PLL_RST: begin
        if (cnt_q >= PULSE_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they change on the edge that enters it.
    pll_rst_d    = (state_d == PLL_RST);
    core_reset_d = (state_d != RUN);
    ready_d      = (state_d == RUN);
    ce_half_d    = (state_d == RUN) && ((state_q != RUN) || !ce_half_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b0;
      core_reset_q <= 1'b1;
      ce_half_q    <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_rst_q    <= pll_rst_d;
      core_reset_q <= core_reset_d;
      ce_half_q    <= ce_half_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.core_reset = core_reset_q;
  assign bus.ce_half    = ce_half_q;
  assign bus.ready      = ready_q;

`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
  logic [7:0] loss_count_q, loss_count_d;

  always_comb begin
    loss_count_d = loss_count_q;
    if ((state_q == RUN) && (state_d == LOST) && (loss_count_q != 8'hFF))
      loss_count_d = loss_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loss_count_q <= '0;
    else        loss_count_q <= loss_count_d;
  end

  assign bus.loss_count = loss_count_q;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits on the output side of the system PLL and consumes its `locked` flag.
- Runs on outclk_0 (35.464 MHz system clock).
- Synchronises and debounces lock, then sequences a clean synchronous core reset.
- Generates a phase-known half-rate clock enable (17.732 MHz equivalent) for logic kept on the single system clock.
- Requests a PLL reset pulse when lock is lost and not regained within a timeout.

Parameters:
- LOCK_CYCLES, 1024: consecutive synchronised-locked cycles required before lock is considered stable.
- HOLD_CYCLES, 16: cycles core reset stays asserted after lock is stable.
- RELOCK_TIMEOUT, 65536: cycles to wait for relock after loss before requesting a PLL reset.
- PLL_RST_CYCLES, 8: width of the pll_rst pulse in cycles.

Ports:
- clk  in  1  system clock (PLL outclk_0).
- rst_n  in  1  asynchronous active-low reset (one clock; async assert, fixed polarity).
- pll_locked  in  1  raw PLL locked flag, asynchronous to clk.
- pll_rst  out  1  reset request to the PLL rst input, active-high.
- core_reset  out  1  synchronous active-high reset for downstream logic.
- ce_half  out  1  clock enable, high every other cycle while running.
- ready  out  1  high in RUN state only.

Behaviour:
- pll_locked passes through a 2-flop synchroniser (lock_s); its latency is excluded from every count below.
- Reset values (rst_n low): state=WAIT_LOCK, pll_rst=0, core_reset=1, ce_half=0, ready=0, all counters 0. Reset mid-operation aborts any sequence immediately, including a pll_rst pulse in progress (pll_rst drops asynchronously).
- Single counter cnt; width = clog2 of the largest parameter (+1); it saturates and never wraps.
- State machine:
  - WAIT_LOCK: core_reset=1, cnt=0. lock_s=1 → STABLE.
  - STABLE: cnt increments each lock_s=1 cycle. lock_s=0 → cnt=0, back to WAIT_LOCK (debounce). cnt==LOCK_CYCLES-1 with lock_s=1 → HOLD, cnt=0.
  - HOLD: core_reset=1; cnt increments. lock_s=0 → LOST. cnt==HOLD_CYCLES-1 → RUN; core_reset deasserts on the same clock edge that registers RUN.
  - RUN: core_reset=0, ready=1, ce_half toggles every cycle. The first RUN cycle has ce_half=1. lock_s=0 → LOST; core_reset=1, ready=0 and ce_half=0 all registered on that edge.
  - LOST: core_reset=1, cnt increments. lock_s=1 → STABLE, cnt=0 (full re-debounce). cnt==RELOCK_TIMEOUT-1 → PLL_RST, cnt=0.
  - PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, ignoring lock_s; then → WAIT_LOCK.
- core_reset and pll_rst are registered outputs; no combinational path from pll_locked.
- Simultaneous events: if lock_s falls in the same cycle a count hits its terminal value, the lock loss wins.
- ce_half is 0 in every state except RUN.

Optional Feature:
- Macro PLL_RESET_SEQUENCER_LOSS_COUNT_EN.
- When defined: adds output `loss_count` [7:0], a saturating count of RUN→LOST transitions. Resets to 0 only on rst_n and holds at 255.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pll_seq_pkg holds:
  - state enum: WAIT_LOCK, STABLE, HOLD, RUN, LOST, PLL_RST;
  - default parameter constants;
  - counter width function.
- One natural sub-module: sync_2ff (generic 2-flop bit synchroniser with async active-low reset), reused elsewhere for async inputs.

Test Plan:
- Release rst_n with pll_locked=1 constant → core_reset falls exactly 2+1024+16 cycles later (2 for the synchroniser); ready rises the same cycle; ce_half=1 on that cycle, then alternates 0,1,0…
- pll_locked glitches low 1 cycle at STABLE count 500 → count restarts; core_reset release is delayed by 500+glitch cycles relative to the clean case.
- In RUN, drop pll_locked for 100 cycles and then restore → core_reset=1 and ready=0 two cycles after the drop; no pll_rst; after restore, full 1024+16 sequence before RUN again.
- Drop pll_locked permanently in RUN → pll_rst high for exactly 8 cycles starting 65536 cycles after entering LOST, then state is WAIT_LOCK with pll_rst=0.
- Assert rst_n low during the pll_rst pulse and during HOLD → all outputs immediately take reset values asynchronously, without waiting for a clk edge.
- With PLL_RESET_SEQUENCER_LOSS_COUNT_EN: 3 RUN→LOST cycles → loss_count=3; force 300 losses → loss_count=255.
